display_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 8-anode, active-low 7-segment display.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/scan_timer.sv | 32 +++
 rtl/display_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_e;

   localparam logic [7:0] ANODES_OFF = 8'hFF;
   localparam int         DIGIT_W    = 4;

   // A digit k>0 is a leading zero when its nibble and all nibbles above it are zero.
   function automatic logic lz_blank(input logic [1:0] k, input logic [15:0] v);
      logic [15:0] upper;
      upper = v >> {k, 2'b00};
      return (k != 2'd0) && (upper == 16'h0000);
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a slot
// loaded with N-1 lasts exactly N cycles.
module scan_timer #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          done
);

   logic [CW-1:0] cnt_q, cnt_d;

   // Reload on a slot change, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scan controller for a multiplexed active-low 7-segment display. Steps through
// the digits with a blanking gap between them and swaps in new values only at
// frame boundaries (or while idle) so a frame is never torn.
module display_scan_ctrl
   import disp_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 100000,
   parameter int BLANK_CYC  = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        lz_suppress,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   output logic [1:0]  digit_sel,
   output logic [3:0]  digit_val,
   output logic [7:0]  anode_ON,
   output logic        frame_done
);

   localparam int CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [1:0]    LAST_DIGIT = 2'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] SHOW_LD    = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LD   = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

   state_e        state_q, state_d;
   logic [1:0]    digit_q, digit_d, nxt_digit;
   logic [15:0]   disp_q, disp_d, pend_q, pend_d;
   logic          pend_v_q, pend_v_d;
   logic [7:0]    anode_q, anode_d;
   logic [3:0]    dval_q, dval_d;
   logic          fdone_q, fdone_d;
   logic          t_load, t_done, boundary, accept, apply;
   logic [CW-1:0] t_val;

   scan_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (t_load),
      .load_val (t_val),
      .done     (t_done)
   );

   // Next-state, handshake and registered-output computation.
   always_comb begin
      state_d   = state_q;
      digit_d   = digit_q;
      disp_d    = disp_q;
      pend_d    = pend_q;
      pend_v_d  = pend_v_q;
      t_load    = 1'b0;
      t_val     = '0;
      boundary  = 1'b0;
      nxt_digit = (digit_q == LAST_DIGIT) ? 2'd0 : digit_q + 2'd1;

      if (!enable) begin
         // Dropping enable parks everything; the counter is cleared on the way out.
         t_load  = (state_q != IDLE);
         state_d = IDLE;
         digit_d = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SHOW;
               digit_d = 2'd0;
               t_load  = 1'b1;
               t_val   = SHOW_LD;
            end
            SHOW: begin
               if (t_done) begin
                  t_load = 1'b1;
                  if (BLANK_CYC > 0) begin
                     state_d = BLANK;
                     t_val   = BLANK_LD;
                  end else begin
                     digit_d  = nxt_digit;
                     t_val    = SHOW_LD;
                     boundary = (digit_q == LAST_DIGIT);
                  end
               end
            end
            BLANK: begin
               if (t_done) begin
                  state_d  = SHOW;
                  digit_d  = nxt_digit;
                  t_load   = 1'b1;
                  t_val    = SHOW_LD;
                  boundary = (digit_q == LAST_DIGIT);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // A load taken on an apply cycle skips the pending register entirely.
      accept = load_valid && !pend_v_q;
      apply  = boundary || (state_q == IDLE);
      if (apply) begin
         if (accept)        disp_d = load_data;
         else if (pend_v_q) disp_d = pend_q;
         pend_v_d = 1'b0;
      end else if (accept) begin
         pend_d   = load_data;
         pend_v_d = 1'b1;
      end

      // Outputs follow the next state so they switch on the same edge.
      anode_d = ANODES_OFF;
      if (state_d == SHOW && !(lz_suppress && lz_blank(digit_d, disp_d)))
         anode_d = ANODES_OFF & ~(8'h01 << digit_d);
      dval_d  = disp_d[{digit_d, 2'b00} +: DIGIT_W];
      fdone_d = boundary;
   end

   // State, data and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         digit_q  <= 2'd0;
         disp_q   <= 16'h0000;
         pend_q   <= 16'h0000;
         pend_v_q <= 1'b0;
         anode_q  <= ANODES_OFF;
         dval_q   <= 4'h0;
         fdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         digit_q  <= digit_d;
         disp_q   <= disp_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         anode_q  <= anode_d;
         dval_q   <= dval_d;
         fdone_q  <= fdone_d;
      end
   end

   assign load_ready = !pend_v_q;
   assign digit_sel  = digit_q;
   assign digit_val  = dval_q;
   assign anode_ON   = anode_q;
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: a frame-position model predicts every cycle's outputs, a
// monitor compares them at the falling edge.
module tb_display_scan_ctrl;

   localparam int ND    = 4;
   localparam int TD    = 4;
   localparam int BC    = 2;
   localparam int SLOT  = TD + BC;
   localparam int FRAME = ND * SLOT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        lz_suppress = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'h0;
   logic        load_ready;
   logic [1:0]  digit_sel;
   logic [3:0]  digit_val;
   logic [7:0]  anode_ON;
   logic        frame_done;

   display_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .lz_suppress (lz_suppress),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .digit_sel   (digit_sel),
      .digit_val   (digit_val),
      .anode_ON    (anode_ON),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] an;
      logic [1:0] sel;
      logic [3:0] val;
      logic       fd;
      logic       rdy;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   // Reference model: scanning flag plus position inside the frame.
   bit          m_scan;
   int          m_t;
   logic [15:0] m_disp, m_pend;
   bit          m_pv;

   task automatic model_reset();
      m_scan = 0; m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 0;
   endtask

   task automatic model_step(input logic en, input logic lz, input logic lv, input logic [15:0] ld);
      bit   acc, bnd, app;
      int   slot, off;
      exp_t e;
      logic [15:0] upper;
      acc = lv && !m_pv;
      bnd = m_scan && en && (m_t == FRAME - 1);
      app = !m_scan || bnd;
      if (app) begin
         if (acc)       m_disp = ld;
         else if (m_pv) m_disp = m_pend;
         m_pv = 0;
      end else if (acc) begin
         m_pend = ld;
         m_pv   = 1;
      end
      if (!en)          m_scan = 0;
      else if (!m_scan) begin m_scan = 1; m_t = 0; end
      else              m_t = (m_t + 1) % FRAME;

      e.fd  = bnd;
      e.rdy = !m_pv;
      e.an  = 8'hFF;
      if (!m_scan) begin
         e.sel = 2'd0;
         e.val = m_disp[3:0];
      end else begin
         slot  = m_t / SLOT;
         off   = m_t % SLOT;
         e.sel = 2'(slot);
         e.val = 4'((m_disp >> (4 * slot)) & 16'hF);
         upper = m_disp >> (4 * slot);
         if (off < TD && !(lz && slot > 0 && upper == 16'h0))
            e.an = ~(8'h01 << slot);
      end
      q.push_back(e);
   endtask

   // Drive one cycle of inputs, then predict the outputs after the edge.
   task automatic tick(input logic en, input logic lz, input logic lv, input logic [15:0] ld);
      enable = en; lz_suppress = lz; load_valid = lv; load_data = ld;
      @(posedge clk); #1;
      cyc++;
      model_step(en, lz, lv, ld);
   endtask

   task automatic check_reset(input string name);
      vectors++;
      if (anode_ON !== 8'hFF || digit_sel !== 2'd0 || digit_val !== 4'h0 ||
          frame_done !== 1'b0 || load_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s: an=%h sel=%0d val=%h fd=%b rdy=%b, want an=ff sel=0 val=0 fd=0 rdy=1",
                  name, anode_ON, digit_sel, digit_val, frame_done, load_ready);
      end
   endtask

   // Monitor: pop and compare each predicted cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (anode_ON !== e.an || digit_sel !== e.sel || digit_val !== e.val ||
                frame_done !== e.fd || load_ready !== e.rdy) begin
               miscompares++;
               $display("FAIL cycle %0d: got an=%h sel=%0d val=%h fd=%b rdy=%b, want an=%h sel=%0d val=%h fd=%b rdy=%b",
                        cyc, anode_ON, digit_sel, digit_val, frame_done, load_ready,
                        e.an, e.sel, e.val, e.fd, e.rdy);
            end
         end
      end
   end

   initial begin
      model_reset();
      // Reset state
      #23;
      check_reset("reset_state");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Load while idle applies immediately
      tick(1'b0, 1'b0, 1'b1, 16'h1234);
      tick(1'b0, 1'b0, 1'b0, 16'h0);

      // Start scanning: two full frames with digit values 4,3,2,1
      for (int i = 0; i < 2 * FRAME; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);

      // Mid-frame load waits for the boundary
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
      tick(1'b1, 1'b0, 1'b1, 16'hABCD);
      for (int i = 0; i < 2 * FRAME; i++) tick(1'b1, 1'b0, 1'b1, 16'h5555);

      // Leading-zero suppression with 0050
      for (int i = 0; i < FRAME && !(m_pv == 0); i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
      tick(1'b1, 1'b1, 1'b1, 16'h0050);
      for (int i = 0; i < 2 * FRAME; i++) tick(1'b1, 1'b1, 1'b0, 16'h0);

      // Drop enable during SHOW of digit 2, then restart
      for (int i = 0; i < FRAME && !(m_scan && m_t == 2 * SLOT + 1); i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
      tick(1'b0, 1'b0, 1'b0, 16'h0);
      tick(1'b0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < FRAME + 3; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);

      // Reset mid-BLANK with a load pending
      for (int i = 0; i < FRAME && !(m_scan && m_t == 0); i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
      tick(1'b1, 1'b0, 1'b1, 16'h5A5A);
      for (int i = 0; i < FRAME && !(m_scan && m_t == TD); i++) tick(1'b1, 1'b0, 1'b0, 16'h0);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_reset_mid_blank");
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < FRAME + 2; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);

      // Randomized traffic
      begin
         logic lz_r;
         lz_r = 1'b0;
         for (int i = 0; i < 800; i++) begin
            logic [15:0] d;
            if ($urandom_range(0, 39) == 0) lz_r = ~lz_r;
            d = ($urandom_range(0, 2) == 0) ? {12'h0, 4'($urandom)} : 16'($urandom);
            tick($urandom_range(0, 49) != 0, lz_r, $urandom_range(0, 5) == 0, d);
         end
      end

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
